// File: rtl/cluster_data_demux_n.sv
// cluster_data_demux_n
// Routes one core request port onto N_TARGETS downstream ports using a
// base/mask address decode (lowest matching index wins). Responses are
// returned in order by only allowing outstanding requests to a single
// target at a time. Unmatched addresses are answered locally with an
// error response one cycle after acceptance.
//
// Optional feature macro: CLUSTER_DEMUX_PERF_EN
//   defined   -> perf_stall_o / perf_err_o event pulses are generated
//   undefined -> perf_stall_o / perf_err_o are tied low (default build)

module cluster_data_demux_n #(
    parameter int N_TARGETS       = 3,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    localparam int BE_WIDTH       = DATA_WIDTH / 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,

    input  logic [N_TARGETS*ADDR_WIDTH-1:0]  addr_base_i,
    input  logic [N_TARGETS*ADDR_WIDTH-1:0]  addr_mask_i,

    input  logic                             core_req_i,
    input  logic                             core_wen_i,
    input  logic [ADDR_WIDTH-1:0]            core_add_i,
    input  logic [DATA_WIDTH-1:0]            core_wdata_i,
    input  logic [BE_WIDTH-1:0]              core_be_i,

    output logic                             core_gnt_o,
    output logic                             core_r_valid_o,
    output logic                             core_r_opc_o,
    output logic [DATA_WIDTH-1:0]            core_r_rdata_o,

    output logic [N_TARGETS-1:0]             tgt_req_o,
    output logic [N_TARGETS-1:0]             tgt_wen_o,
    output logic [N_TARGETS*ADDR_WIDTH-1:0]  tgt_add_o,
    output logic [N_TARGETS*DATA_WIDTH-1:0]  tgt_wdata_o,
    output logic [N_TARGETS*BE_WIDTH-1:0]    tgt_be_o,

    input  logic [N_TARGETS-1:0]             tgt_gnt_i,
    input  logic [N_TARGETS-1:0]             tgt_r_valid_i,
    input  logic [N_TARGETS-1:0]             tgt_r_opc_i,
    input  logic [N_TARGETS*DATA_WIDTH-1:0]  tgt_r_rdata_i,

    output logic                             perf_stall_o,
    output logic                             perf_err_o
);

    // Target index needs one extra code point for the internal error slave.
    localparam int              TGT_W   = $clog2(N_TARGETS + 1);
    localparam logic [TGT_W-1:0] ERR_IDX = TGT_W'(N_TARGETS);

    // Counter must be able to hold MAX_OUTSTANDING itself.
    localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    localparam logic [31:0] ERR_WORD = 32'hBADACCE5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TGT_W-1:0]   last_tgt_q, last_tgt_d;
    logic               err_pend_q, err_pend_d;

    logic               match_found;
    logic [TGT_W-1:0]   match_idx;
    logic               match_gnt;
    logic               admissible;
    logic               accept;

    logic               tgt_rsp_valid;
    logic               tgt_rsp_opc;
    logic [DATA_WIDTH-1:0] tgt_rsp_rdata;
    logic               rsp_from_tgt;
    logic               rsp;
    logic [DATA_WIDTH-1:0] err_rdata;

    // Error payload, zero-extended or truncated to the data width.
    always_comb begin
        err_rdata = '0;
        for (int b = 0; b < DATA_WIDTH && b < 32; b++) begin
            err_rdata[b] = ERR_WORD[b];
        end
    end

    // Address decode: scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        match_found = 1'b0;
        match_idx   = ERR_IDX;
        match_gnt   = 1'b1;
        for (int t = N_TARGETS - 1; t >= 0; t--) begin
            if ((core_add_i & addr_mask_i[t*ADDR_WIDTH +: ADDR_WIDTH]) ==
                (addr_base_i[t*ADDR_WIDTH +: ADDR_WIDTH] & addr_mask_i[t*ADDR_WIDTH +: ADDR_WIDTH])) begin
                match_found = 1'b1;
                match_idx   = TGT_W'(t);
                match_gnt   = tgt_gnt_i[t];
            end
        end
    end

    // A request may only go out if there is room and it keeps responses in order.
    always_comb begin
        admissible = (state_q != S_FULL) &&
                     ((state_q == S_IDLE) || (match_idx == last_tgt_q));
        core_gnt_o = admissible && match_gnt && !rst_i;
        accept     = core_req_i && core_gnt_o;
    end

    // Forward the request to the matched target only. The request is also held back
    // while not admissible so a target can never take a transfer the core was not granted.
    always_comb begin
        tgt_req_o = '0;
        for (int t = 0; t < N_TARGETS; t++) begin
            tgt_req_o[t] = core_req_i && match_found && (match_idx == TGT_W'(t)) &&
                           admissible && !rst_i;
        end
        tgt_wen_o   = {N_TARGETS{core_wen_i}};
        tgt_add_o   = {N_TARGETS{core_add_i}};
        tgt_wdata_o = {N_TARGETS{core_wdata_i}};
        tgt_be_o    = {N_TARGETS{core_be_i}};
    end

    // Select the response channel of the target that currently owns the outstanding requests.
    always_comb begin
        tgt_rsp_valid = 1'b0;
        tgt_rsp_opc   = 1'b0;
        tgt_rsp_rdata = '0;
        for (int t = 0; t < N_TARGETS; t++) begin
            if (last_tgt_q == TGT_W'(t)) begin
                tgt_rsp_valid = tgt_r_valid_i[t];
                tgt_rsp_opc   = tgt_r_opc_i[t];
                tgt_rsp_rdata = tgt_r_rdata_i[t*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Merge target and local error responses; stray responses with nothing outstanding are dropped.
    always_comb begin
        rsp_from_tgt   = tgt_rsp_valid && (state_q != S_IDLE);
        rsp            = rsp_from_tgt || err_pend_q;
        core_r_valid_o = rsp;
        core_r_opc_o   = 1'b0;
        core_r_rdata_o = '0;
        if (err_pend_q) begin
            core_r_opc_o   = 1'b1;
            core_r_rdata_o = err_rdata;
        end else if (rsp_from_tgt) begin
            core_r_opc_o   = tgt_rsp_opc;
            core_r_rdata_o = tgt_rsp_rdata;
        end
    end

    // Outstanding bookkeeping: count, owning target and pending error reply.
    always_comb begin
        count_d    = count_q;
        last_tgt_d = last_tgt_q;
        err_pend_d = accept && !match_found;
        if (accept && !rsp) begin
            count_d = count_q + CNT_W'(1);
        end else if (!accept && rsp) begin
            count_d = count_q - CNT_W'(1);
        end
        if (accept) begin
            last_tgt_d = match_idx;
        end
    end

    // Occupancy state machine, following the outstanding count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (count_d == MAX_CNT) begin
                    state_d = S_FULL;
                end else if (count_d != '0) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (count_d == '0) begin
                    state_d = S_IDLE;
                end else if (count_d == MAX_CNT) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (count_d == '0) begin
                    state_d = S_IDLE;
                end else if (count_d != MAX_CNT) begin
                    state_d = S_BUSY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset discards all outstanding tracking.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            last_tgt_q <= '0;
            err_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            last_tgt_q <= last_tgt_d;
            err_pend_q <= err_pend_d;
        end
    end

`ifdef CLUSTER_DEMUX_PERF_EN
    logic perf_err_q, perf_err_d;

    // Decode-error event, aligned with the error reply it produced.
    always_comb begin
        perf_err_d = accept && !match_found;
    end

    // Register for the decode-error event pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_err_q <= 1'b0;
        end else begin
            perf_err_q <= perf_err_d;
        end
    end

    assign perf_stall_o = core_req_i && !core_gnt_o && !rst_i;
    assign perf_err_o   = perf_err_q;
`else
    assign perf_stall_o = 1'b0;
    assign perf_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_cluster_data_demux_n.sv
// Directed testbench for cluster_data_demux_n with the default parameters
// (3 targets, 32-bit address/data, 4 outstanding).

module tb_cluster_data_demux_n;

`ifdef CLUSTER_DEMUX_PERF_EN
   localparam logic PERF_ON = 1'b1;
`else
   localparam logic PERF_ON = 1'b0;
`endif

   localparam logic [31:0] ADDR_T0  = 32'h1000_0040;
   localparam logic [31:0] ADDR_T0B = 32'h1020_0000;
   localparam logic [31:0] ADDR_T2  = 32'h1A10_0004;
   localparam logic [31:0] ADDR_ERR = 32'h2000_0000;

   logic        clock;
   logic        reset;
   logic [95:0] addrBase;
   logic [95:0] addrMask;
   logic        coreReq;
   logic        coreWen;
   logic [31:0] coreAdd;
   logic [31:0] coreWdata;
   logic [3:0]  coreBe;
   logic        coreGnt;
   logic        coreRValid;
   logic        coreROpc;
   logic [31:0] coreRRdata;
   logic [2:0]  tgtReq;
   logic [2:0]  tgtWen;
   logic [95:0] tgtAdd;
   logic [95:0] tgtWdata;
   logic [11:0] tgtBe;
   logic [2:0]  tgtGnt;
   logic [2:0]  tgtRValid;
   logic [2:0]  tgtROpc;
   logic [95:0] tgtRRdata;
   logic        perfStall;
   logic        perfErr;

   int nChecks = 0;
   int nFails  = 0;

   cluster_data_demux_n dut (
      .clk_i          (clock),
      .rst_i          (reset),
      .addr_base_i    (addrBase),
      .addr_mask_i    (addrMask),
      .core_req_i     (coreReq),
      .core_wen_i     (coreWen),
      .core_add_i     (coreAdd),
      .core_wdata_i   (coreWdata),
      .core_be_i      (coreBe),
      .core_gnt_o     (coreGnt),
      .core_r_valid_o (coreRValid),
      .core_r_opc_o   (coreROpc),
      .core_r_rdata_o (coreRRdata),
      .tgt_req_o      (tgtReq),
      .tgt_wen_o      (tgtWen),
      .tgt_add_o      (tgtAdd),
      .tgt_wdata_o    (tgtWdata),
      .tgt_be_o       (tgtBe),
      .tgt_gnt_i      (tgtGnt),
      .tgt_r_valid_i  (tgtRValid),
      .tgt_r_opc_i    (tgtROpc),
      .tgt_r_rdata_i  (tgtRRdata),
      .perf_stall_o   (perfStall),
      .perf_err_o     (perfErr)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Advance to just after the next rising edge, where inputs are changed.
   task tick;
      @(posedge clock);
      #1;
   endtask

   // Drive the core request port.
   task applyStimulus(input logic req, input logic [31:0] add, input logic wen);
      coreReq   = req;
      coreAdd   = add;
      coreWen   = wen;
      coreWdata = add ^ 32'h5A5A_5A5A;
      coreBe    = 4'hF;
   endtask

   task test_reset;
      reset = 1'b1;
      tgtGnt = 3'b111;
      applyStimulus(1'b1, ADDR_T0, 1'b0);
      #1;
      nChecks++; if (coreGnt !== 1'b0) begin nFails++; $display("[TB] FAIL reset_gnt got %b want 0", coreGnt); end
      nChecks++; if (coreRValid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_rvalid got %b want 0", coreRValid); end
      nChecks++; if (tgtReq !== 3'b000) begin nFails++; $display("[TB] FAIL reset_tgt_req got %b want 000", tgtReq); end
      nChecks++; if (perfStall !== 1'b0) begin nFails++; $display("[TB] FAIL reset_perf_stall got %b want 0", perfStall); end
      nChecks++; if (perfErr !== 1'b0) begin nFails++; $display("[TB] FAIL reset_perf_err got %b want 0", perfErr); end
      applyStimulus(1'b0, 32'h0, 1'b0);
      tick;
      reset = 1'b0;
      tick;
   endtask

   task test_decode;
      tgtGnt = 3'b001;
      applyStimulus(1'b1, ADDR_T0, 1'b0);
      #1;
      nChecks++; if (tgtReq !== 3'b001) begin nFails++; $display("[TB] FAIL decode_t0_req got %b want 001", tgtReq); end
      nChecks++; if (coreGnt !== 1'b1) begin nFails++; $display("[TB] FAIL decode_t0_gnt got %b want 1", coreGnt); end
      nChecks++; if (tgtAdd[95:64] !== ADDR_T0) begin nFails++; $display("[TB] FAIL decode_add_fanout got %h want %h", tgtAdd[95:64], ADDR_T0); end
      tgtGnt = 3'b000;
      #1;
      nChecks++; if (coreGnt !== 1'b0) begin nFails++; $display("[TB] FAIL decode_gnt_echo got %b want 0", coreGnt); end
      nChecks++; if (perfStall !== PERF_ON) begin nFails++; $display("[TB] FAIL decode_perf_stall got %b want %b", perfStall, PERF_ON); end
      tgtGnt = 3'b111;
      applyStimulus(1'b1, ADDR_T0B, 1'b0);
      #1;
      nChecks++; if (tgtReq !== 3'b001) begin nFails++; $display("[TB] FAIL decode_lowest_wins got %b want 001", tgtReq); end
      applyStimulus(1'b1, ADDR_T2, 1'b1);
      #1;
      nChecks++; if (tgtReq !== 3'b100) begin nFails++; $display("[TB] FAIL decode_t2_req got %b want 100", tgtReq); end
      nChecks++; if (tgtWen !== 3'b111) begin nFails++; $display("[TB] FAIL decode_wen_fanout got %b want 111", tgtWen); end
      applyStimulus(1'b0, 32'h0, 1'b0);
      tick;
   endtask

   task test_outstanding;
      tgtGnt = 3'b111;
      applyStimulus(1'b1, ADDR_T0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1;
         nChecks++; if (coreGnt !== 1'b1) begin nFails++; $display("[TB] FAIL outstanding_gnt%0d got %b want 1", i, coreGnt); end
         tick;
      end
      #1;
      nChecks++; if (coreGnt !== 1'b0) begin nFails++; $display("[TB] FAIL outstanding_full_gnt got %b want 0", coreGnt); end
      nChecks++; if (perfStall !== PERF_ON) begin nFails++; $display("[TB] FAIL outstanding_perf_stall got %b want %b", perfStall, PERF_ON); end
      tgtRValid = 3'b001;
      tgtROpc = 3'b000;
      tgtRRdata[31:0] = 32'h1111_2222;
      #1;
      nChecks++; if (coreRValid !== 1'b1) begin nFails++; $display("[TB] FAIL outstanding_rvalid got %b want 1", coreRValid); end
      nChecks++; if (coreRRdata !== 32'h1111_2222) begin nFails++; $display("[TB] FAIL outstanding_rdata got %h want 11112222", coreRRdata); end
      nChecks++; if (coreROpc !== 1'b0) begin nFails++; $display("[TB] FAIL outstanding_ropc got %b want 0", coreROpc); end
      tick;
      tgtRValid = 3'b000;
      #1;
      nChecks++; if (coreGnt !== 1'b1) begin nFails++; $display("[TB] FAIL outstanding_fifth_gnt got %b want 1", coreGnt); end
      tick;
      applyStimulus(1'b0, 32'h0, 1'b0);
      tgtRValid = 3'b010;
      #1;
      nChecks++; if (coreRValid !== 1'b0) begin nFails++; $display("[TB] FAIL outstanding_foreign_rvalid got %b want 0", coreRValid); end
      for (int i = 0; i < 4; i++) begin
         tgtRValid = 3'b001;
         tick;
      end
      #1;
      nChecks++; if (coreRValid !== 1'b0) begin nFails++; $display("[TB] FAIL outstanding_drop_idle got %b want 0", coreRValid); end
      tgtRValid = 3'b000;
      tick;
   endtask

   task test_switch;
      tgtGnt = 3'b111;
      applyStimulus(1'b1, ADDR_T0, 1'b0);
      #1;
      nChecks++; if (coreGnt !== 1'b1) begin nFails++; $display("[TB] FAIL switch_first_gnt got %b want 1", coreGnt); end
      tick;
      applyStimulus(1'b1, ADDR_T2, 1'b0);
      #1;
      nChecks++; if (coreGnt !== 1'b0) begin nFails++; $display("[TB] FAIL switch_blocked_gnt got %b want 0", coreGnt); end
      nChecks++; if (tgtReq !== 3'b000) begin nFails++; $display("[TB] FAIL switch_blocked_req got %b want 000", tgtReq); end
      tick;
      tgtRValid = 3'b001;
      tgtROpc = 3'b001;
      #1;
      nChecks++; if (coreGnt !== 1'b0) begin nFails++; $display("[TB] FAIL switch_rsp_cycle_gnt got %b want 0", coreGnt); end
      nChecks++; if (coreRValid !== 1'b1 || coreROpc !== 1'b1) begin nFails++; $display("[TB] FAIL switch_t0_rsp got %b/%b want 1/1", coreRValid, coreROpc); end
      tick;
      tgtRValid = 3'b000;
      tgtROpc = 3'b000;
      #1;
      nChecks++; if (coreGnt !== 1'b1) begin nFails++; $display("[TB] FAIL switch_granted got %b want 1", coreGnt); end
      nChecks++; if (tgtReq !== 3'b100) begin nFails++; $display("[TB] FAIL switch_t2_req got %b want 100", tgtReq); end
      tick;
      applyStimulus(1'b0, 32'h0, 1'b0);
      tgtRValid = 3'b100;
      tgtROpc = 3'b100;
      tgtRRdata[95:64] = 32'hCAFE_0002;
      #1;
      nChecks++; if (coreRValid !== 1'b1) begin nFails++; $display("[TB] FAIL switch_t2_rvalid got %b want 1", coreRValid); end
      nChecks++; if (coreRRdata !== 32'hCAFE_0002) begin nFails++; $display("[TB] FAIL switch_t2_rdata got %h want cafe0002", coreRRdata); end
      nChecks++; if (coreROpc !== 1'b1) begin nFails++; $display("[TB] FAIL switch_t2_ropc got %b want 1", coreROpc); end
      tick;
      tgtRValid = 3'b000;
      tgtROpc = 3'b000;
      tick;
   endtask

   task test_error;
      tgtGnt = 3'b111;
      applyStimulus(1'b1, ADDR_ERR, 1'b0);
      #1;
      nChecks++; if (coreGnt !== 1'b1) begin nFails++; $display("[TB] FAIL error_gnt got %b want 1", coreGnt); end
      nChecks++; if (tgtReq !== 3'b000) begin nFails++; $display("[TB] FAIL error_no_tgt_req got %b want 000", tgtReq); end
      nChecks++; if (coreRValid !== 1'b0) begin nFails++; $display("[TB] FAIL error_early_rvalid got %b want 0", coreRValid); end
      tick;
      applyStimulus(1'b0, 32'h0, 1'b0);
      #1;
      nChecks++; if (coreRValid !== 1'b1) begin nFails++; $display("[TB] FAIL error_rvalid got %b want 1", coreRValid); end
      nChecks++; if (coreROpc !== 1'b1) begin nFails++; $display("[TB] FAIL error_ropc got %b want 1", coreROpc); end
      nChecks++; if (coreRRdata !== 32'hBADACCE5) begin nFails++; $display("[TB] FAIL error_rdata got %h want badacce5", coreRRdata); end
      nChecks++; if (perfErr !== PERF_ON) begin nFails++; $display("[TB] FAIL error_perf_err got %b want %b", perfErr, PERF_ON); end
      tick;
      #1;
      nChecks++; if (coreRValid !== 1'b0) begin nFails++; $display("[TB] FAIL error_single_rvalid got %b want 0", coreRValid); end
      nChecks++; if (perfErr !== 1'b0) begin nFails++; $display("[TB] FAIL error_perf_err_pulse got %b want 0", perfErr); end
      tick;
   endtask

   task test_back_to_back;
      tgtGnt = 3'b111;
      applyStimulus(1'b1, ADDR_T0, 1'b0);
      tick;
      tick;
      tgtRValid = 3'b001;
      #1;
      nChecks++; if (coreGnt !== 1'b1 || coreRValid !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_simul got gnt %b rvalid %b want 1/1", coreGnt, coreRValid); end
      tick;
      tgtRValid = 3'b000;
      tick;
      #1;
      nChecks++; if (coreGnt !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_count3_gnt got %b want 1", coreGnt); end
      reset = 1'b1;
      #1;
      nChecks++; if (coreGnt !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_reset_gnt got %b want 0", coreGnt); end
      nChecks++; if (tgtReq !== 3'b000) begin nFails++; $display("[TB] FAIL b2b_reset_req got %b want 000", tgtReq); end
      tgtRValid = 3'b001;
      #1;
      nChecks++; if (coreRValid !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_reset_rvalid got %b want 0", coreRValid); end
      tick;
      reset = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0);
      #1;
      nChecks++; if (coreRValid !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_late_rsp got %b want 0", coreRValid); end
      tick;
      tgtRValid = 3'b000;
      applyStimulus(1'b1, ADDR_T0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1;
         nChecks++; if (coreGnt !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_refill_gnt%0d got %b want 1", i, coreGnt); end
         tick;
      end
      #1;
      nChecks++; if (coreGnt !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_refill_full got %b want 0", coreGnt); end
      applyStimulus(1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tgtRValid = 3'b001;
         tick;
      end
      tgtRValid = 3'b000;
      tick;
   endtask

   // Main sequence.
   initial begin
      reset     = 1'b1;
      addrBase  = {32'h1A10_0000, 32'h1020_0000, 32'h1000_0000};
      addrMask  = {32'hFFF0_0000, 32'hFFFF_C000, 32'hFFC0_0000};
      tgtGnt    = 3'b000;
      tgtRValid = 3'b000;
      tgtROpc   = 3'b000;
      tgtRRdata = '0;
      applyStimulus(1'b0, 32'h0, 1'b0);
      repeat (2) @(posedge clock);
      #1;
      test_reset;
      test_decode;
      test_outstanding;
      test_switch;
      test_error;
      test_back_to_back;
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
